// File: rtl/bus_read_ctrl_pkg.sv
// Shared processor package: common-bus source select codes and read-controller state encodings.
package bus_read_ctrl_pkg;

  typedef enum logic [2:0] {
    SRC_AC  = 3'd0,
    SRC_AR  = 3'd1,
    SRC_DR  = 3'd2,
    SRC_IR  = 3'd3,
    SRC_PC  = 3'd4,
    SRC_R   = 3'd5,
    SRC_TR  = 3'd6,
    SRC_MEM = 3'd7
  } src_sel_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REG      = 3'd1,
    ST_MEM_REQ  = 3'd2,
    ST_MEM_WAIT = 3'd3,
    ST_DONE     = 3'd4
  } rd_state_t;

endpackage

// File: rtl/bus_read_ctrl_src_mux.sv
// bus_src_mux: combinational 8:1 register source select onto the common bus, AR zero-extended.
import bus_read_ctrl_pkg::*;

module bus_src_mux #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic [2:0]        select,
  input  logic [DATA_W-1:0] ac,
  input  logic [ADDR_W-1:0] ar,
  input  logic [DATA_W-1:0] dr,
  input  logic [DATA_W-1:0] ir,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] r,
  input  logic [DATA_W-1:0] tr,
  output logic [DATA_W-1:0] data
);

  // Memory code yields zero here; memory data takes the separate MEM_WAIT path.
  always_comb begin
    data = '0;
    case (src_sel_t'(select))
      SRC_AC:  data = ac;
      SRC_AR:  data = DATA_W'(ar);
      SRC_DR:  data = dr;
      SRC_IR:  data = ir;
      SRC_PC:  data = pc;
      SRC_R:   data = r;
      SRC_TR:  data = tr;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/bus_read_ctrl.sv
// Common-bus read controller: register reads in 3 cycles, memory reads via a mem_rd/mem_ready handshake.
// Optional MEM_WAIT watchdog enabled by defining BUS_READ_TIMEOUT_EN.
import bus_read_ctrl_pkg::*;

module bus_read_ctrl #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 12,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [2:0]        select,
  input  logic [DATA_W-1:0] ac,
  input  logic [ADDR_W-1:0] ar,
  input  logic [DATA_W-1:0] dr,
  input  logic [DATA_W-1:0] ir,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] r,
  input  logic [DATA_W-1:0] tr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_valid,
  output logic              busy,
  output logic              bus_err,
  output rd_state_t         fsm_state
);

  // Handshakes: req is a level accepted only when busy=0 (never queued); mem_rd is a
  // one-cycle strobe, after which mem_ready=1 in MEM_WAIT delivers mem_rdata; bus_valid
  // is a one-cycle pulse with bus_data already stable in that cycle.

  rd_state_t         state, next_state;
  logic [DATA_W-1:0] src_data;
  logic              load_src, load_addr, load_mem, time_out, accept;

  bus_src_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_src_mux (
    .select (select),
    .ac     (ac),
    .ar     (ar),
    .dr     (dr),
    .ir     (ir),
    .pc     (pc),
    .r      (r),
    .tr     (tr),
    .data   (src_data)
  );

`ifdef BUS_READ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_expired;

  assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    wait_cnt <= '0;
    else if (state == ST_MEM_WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
    else                           wait_cnt <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        bus_err <= 1'b0;
    else if (accept)   bus_err <= 1'b0;
    else if (time_out) bus_err <= 1'b1;
  end
`else
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    load_src   = 1'b0;
    load_addr  = 1'b0;
    load_mem   = 1'b0;
    time_out   = 1'b0;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (src_sel_t'(select) == SRC_MEM) begin
            load_addr  = 1'b1;
            next_state = ST_MEM_REQ;
          end else begin
            load_src   = 1'b1;
            next_state = ST_REG;
          end
        end
      end
      ST_REG:     next_state = ST_DONE;
      ST_MEM_REQ: next_state = ST_MEM_WAIT;
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          load_mem   = 1'b1;
          next_state = ST_DONE;
        end
`ifdef BUS_READ_TIMEOUT_EN
        else if (wait_expired) begin
          time_out   = 1'b1;
          next_state = ST_DONE;
        end
`endif
      end
      ST_DONE:    next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Sources are sampled only on the IDLE-exit edge; results hold until the next completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_data <= '0;
      mem_addr <= '0;
    end else begin
      if (load_src)      bus_data <= src_data;
      else if (load_mem) bus_data <= mem_rdata;
      else if (time_out) bus_data <= '0;
      if (load_addr)     mem_addr <= ar;
    end
  end

  assign mem_rd    = (state == ST_MEM_REQ);
  assign bus_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_bus_read_ctrl.sv
// Self-checking bench for bus_read_ctrl: directed cases plus randomized reads against a transaction-level model.
// Timeout cases are exercised when BUS_READ_TIMEOUT_EN is defined.
import bus_read_ctrl_pkg::*;

module tb_bus_read_ctrl;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [2:0]  select;
  logic [15:0] ac, dr, ir, pc, r, tr;
  logic [11:0] ar;
  logic        mem_rd;
  logic [11:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic [15:0] bus_data;
  logic        bus_valid, busy, bus_err;
  rd_state_t   fsm_state;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [11:0] exp_addr;

  bus_read_ctrl #(.DATA_W(16), .ADDR_W(12), .TIMEOUT_CYC(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .select    (select),
    .ac        (ac),
    .ar        (ar),
    .dr        (dr),
    .ir        (ir),
    .pc        (pc),
    .r         (r),
    .tr        (tr),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .bus_data  (bus_data),
    .bus_valid (bus_valid),
    .busy      (busy),
    .bus_err   (bus_err),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: the bus carries the named register, AR widened with zeros.
  function automatic logic [15:0] src_val(input logic [2:0] s);
    logic [15:0] v[8];
    v = '{ac, {4'h0, ar}, dr, ir, pc, r, tr, 16'h0000};
    return v[s];
  endfunction

  task automatic randomize_sources();
    ac = 16'($urandom); dr = 16'($urandom); ir = 16'($urandom);
    pc = 16'($urandom); r  = 16'($urandom); tr = 16'($urandom);
    ar = 12'($urandom);
  endtask

  // One read: d = MEM_WAIT cycles with mem_ready low before the ready cycle.
  // noise adds a dropped req while busy and a stray mem_ready outside MEM_WAIT.
  task automatic do_read(input logic [2:0] s, input int d, input logic [15:0] rd, input bit noise);
    bit          is_mem, tmo;
    int          exp_lat, vcount, rdcount, lat;
    logic [15:0] exp_data;
    is_mem = (s == 3'd7);
    tmo    = 1'b0;
`ifdef BUS_READ_TIMEOUT_EN
    tmo = is_mem && (d >= TMO);
`endif
    exp_lat  = !is_mem ? 2 : (tmo ? 2 + TMO : 3 + d);
    exp_data = tmo ? 16'h0000 : (is_mem ? rd : src_val(s));
    if (is_mem) exp_addr = ar;
    exp_q.push_back(exp_data);
    select = s; req = 1'b1; mem_ready = 1'b0;
    vcount = 0; rdcount = 0; lat = -1;
    for (int k = 1; k <= exp_lat + 3; k++) begin
      @(negedge clk);
      if (k == 1) check("err_cleared_on_accept", bus_err, 0);
      check("busy", busy, (k <= exp_lat));
      if (bus_valid) begin
        vcount++;
        lat = k;
        if (exp_q.size() > 0) check("bus_data_at_valid", bus_data, exp_q.pop_front());
      end
      if (mem_rd) begin
        rdcount++;
        check("mem_addr_at_rd", mem_addr, exp_addr);
      end
      req       = noise && (k == 2);
      select    = (noise && k == 2) ? 3'd0 : s;
      mem_ready = (is_mem && !tmo && k == 2 + d) || (noise && k == 1);
      mem_rdata = (k == 2 + d) ? rd : 16'($urandom);
      if (k == 1) randomize_sources();
    end
    req = 1'b0; mem_ready = 1'b0;
    check("valid_count", vcount, 1);
    check("latency", lat, exp_lat);
    check("mem_rd_count", rdcount, is_mem);
    check("bus_data_hold", bus_data, exp_data);
    check("mem_addr_hold", mem_addr, exp_addr);
    check("bus_err_after", bus_err, tmo);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, observed running expected done");
    $fatal(1, "global timeout");
  end

  initial begin
    int vcount;
    rst_n = 1'b0; req = 1'b0; select = 3'd0; mem_ready = 1'b0; mem_rdata = 16'h0;
    ac = 0; dr = 0; ir = 0; pc = 0; r = 0; tr = 0; ar = 0;
    exp_addr = 12'h000;

    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", bus_valid, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_bus_data", bus_data, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_bus_err", bus_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    pc = 16'h0123;
    do_read(3'd4, 0, 16'h0, 1'b0);
    ar = 12'hABC;
    do_read(3'd1, 0, 16'h0, 1'b0);
    ar = 12'h040;
    do_read(3'd7, 3, 16'hBEEF, 1'b0);
    ar = 12'h555;
    do_read(3'd7, 2, 16'h1234, 1'b1);
    tr = 16'hA5A5;
    do_read(3'd6, 0, 16'h0, 1'b1);
    ar = 12'h3C3;
`ifdef BUS_READ_TIMEOUT_EN
    do_read(3'd7, 40, 16'hDEAD, 1'b0);
`else
    do_read(3'd7, 20, 16'hDEAD, 1'b0);
`endif
    dr = 16'h7E57;
    do_read(3'd2, 0, 16'h0, 1'b0);

    // Back-to-back: req held high through the IDLE cycle after DONE.
    ir = 16'h1111; select = 3'd3; req = 1'b1; vcount = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("b2b_valid", bus_valid, (k == 2 || k == 5));
      if (bus_valid) vcount++;
      if (k == 2) check("b2b_first", bus_data, 16'h1111);
      if (k == 5) check("b2b_second", bus_data, 16'h2222);
      if (k == 1) ir = 16'h2222;
      if (k == 4) req = 1'b0;
    end
    check("b2b_valid_count", vcount, 2);

    for (int t = 0; t < 24; t++) begin
      logic [2:0] s;
      int         d;
      randomize_sources();
      s = 3'($urandom_range(0, 7));
      d = $urandom_range(0, 6);
`ifdef BUS_READ_TIMEOUT_EN
      if ($urandom_range(0, 5) == 0) d = 30;
`endif
      do_read(s, d, 16'($urandom), 1'($urandom_range(0, 1)));
    end

    // Reset in MEM_WAIT: abandon, outputs cleared at once, later mem_ready ignored.
    ar = 12'h777; select = 3'd7; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", bus_valid, 0);
    check("mid_rst_mem_rd", mem_rd, 0);
    check("mid_rst_mem_addr", mem_addr, 0);
    check("mid_rst_bus_data", bus_data, 0);
    check("mid_rst_bus_err", bus_err, 0);
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b1; mem_rdata = 16'hF00D;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("post_rst_no_valid", bus_valid, 0);
      check("post_rst_idle", busy, 0);
    end
    mem_ready = 1'b0;
    exp_addr = 12'h000;
    check("post_rst_bus_data", bus_data, 0);

    ac = 16'hC0DE;
    do_read(3'd0, 0, 16'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
